// File: rtl/crypto_pkg.sv
// crypto_pkg: shared definitions for the crypto execute unit.
// Holds the 2-bit operation encodings, the FSM state type and the default
// datapath width.
package crypto_pkg;

    // Default operand/result width.
    localparam int CRYPTO_DATA_W = 8;

    // Decoded crypto operation, as delivered by the decode stage.
    typedef enum logic [1:0] {
        OP_XOR = 2'b00,
        OP_ADD = 2'b01,
        OP_ROL = 2'b10,
        OP_MIX = 2'b11
    } crypto_op_e;

    // Execute-unit control states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } crypto_state_e;

endpackage : crypto_pkg

// File: rtl/crypto_step.sv
// crypto_step: purely combinational single-step datapath.
// Given the operation and the current working values x and k, it produces
// the values after one step. XOR/ADD/ROL leave k unchanged, and MIX rotates
// it by one bit.
module crypto_step
    import crypto_pkg::*;
#(
    parameter int DATA_W = CRYPTO_DATA_W
) (
    input  crypto_op_e        op,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] k,
    output logic [DATA_W-1:0] x_nxt,
    output logic [DATA_W-1:0] k_nxt
);

    logic [DATA_W-1:0] t;

    // One step of the selected operation; all sums wrap modulo 2^DATA_W.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case can leave it unassigned (no latch).
        x_nxt = x;
        k_nxt = k;
        t     = x ^ k;
        unique case (op)
            OP_XOR: x_nxt = x ^ k;
            OP_ADD: x_nxt = x + k;
            OP_ROL: x_nxt = {x[DATA_W-2:0], x[DATA_W-1]};
            OP_MIX: begin
                x_nxt = {t[DATA_W-2:0], t[DATA_W-1]} + k;
                k_nxt = {k[DATA_W-2:0], k[DATA_W-1]};
            end
        endcase
    end

endmodule : crypto_step

// File: rtl/crypto_exec_unit.sv
// crypto_exec_unit: multi-cycle crypto execute stage with start/busy/done.
// An accepted start latches the operands and a step count. The unit then runs
// one crypto_step per cycle and presents a registered result together with a
// one-cycle done pulse.
// Optional feature: define CRYPTO_EXEC_PARITY_EN to add result_parity (^result).
module crypto_exec_unit
    import crypto_pkg::*;
#(
    parameter int DATA_W = CRYPTO_DATA_W,
    parameter int ROUNDS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] key_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
`ifdef CRYPTO_EXEC_PARITY_EN
    ,
    output logic              result_parity
`endif
);

    localparam int LOG2W = $clog2(DATA_W);
    // The largest step count is either a full rotate or the MIX round count.
    localparam int S_MAX = (ROUNDS > DATA_W) ? ROUNDS : DATA_W;
    localparam int CNT_W = $clog2(S_MAX + 1);

    crypto_state_e     state, state_nxt;
    crypto_op_e        op_q, op_d;
    logic [DATA_W-1:0] x_q, x_d, k_q, k_d;
    logic [DATA_W-1:0] x_step, k_step;
    logic [DATA_W-1:0] res_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  s_load;

    crypto_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .op    (op_q),
        .x     (x_q),
        .k     (k_q),
        .x_nxt (x_step),
        .k_nxt (k_step)
    );

    // Step count implied by the incoming operation; ROL uses the key's count field.
    always_comb begin
        s_load = CNT_W'(1);
        case (crypto_op_e'(op))
            OP_XOR:  s_load = CNT_W'(1);
            OP_ADD:  s_load = CNT_W'(1);
            OP_ROL:  s_load = CNT_W'(key_in[LOG2W-1:0]);
            OP_MIX:  s_load = CNT_W'(ROUNDS);
            default: s_load = CNT_W'(1);
        endcase
    end

    // Next-state logic plus next values of the operand, counter and result registers.
    always_comb begin
        state_nxt = state;
        op_d      = op_q;
        x_d       = x_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        res_d     = result;
        case (state)
            IDLE: begin
                if (start) begin
                    op_d  = crypto_op_e'(op);
                    x_d   = data_in;
                    k_d   = key_in;
                    cnt_d = s_load;
                    if (s_load == '0) begin
                        // Zero-length rotate: nothing to do, x is already final.
                        state_nxt = DONE;
                        res_d     = data_in;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                x_d   = x_step;
                k_d   = k_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_nxt = DONE;
                    res_d     = x_step;
                end
            end
            DONE: begin
                // Always return to IDLE; a start seen here is dropped, not queued.
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Working registers, counter, result and registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q   <= OP_XOR;
            x_q    <= '0;
            k_q    <= '0;
            cnt_q  <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            op_q   <= op_d;
            x_q    <= x_d;
            k_q    <= k_d;
            cnt_q  <= cnt_d;
            result <= res_d;
            busy   <= (state_nxt != IDLE);
            done   <= (state_nxt == DONE);
        end
    end

`ifdef CRYPTO_EXEC_PARITY_EN
    // Parity flop loads alongside result, so the two always stay consistent.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_parity <= 1'b0;
        end else begin
            result_parity <= ^res_d;
        end
    end
`endif

endmodule : crypto_exec_unit

// File: tb/tb_crypto_exec_unit.sv
// tb_crypto_exec_unit: self-checking bench for crypto_exec_unit.
// Directed cases plus randomized operations, each compared against a
// behavioural model that computes the result and latency directly.
// The bench also covers CRYPTO_EXEC_PARITY_EN when that macro is defined.
module tb_crypto_exec_unit;

    localparam int W    = 8;
    localparam int R    = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] data_in;
    logic [W-1:0] key_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
`ifdef CRYPTO_EXEC_PARITY_EN
    logic         result_parity;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    crypto_exec_unit #(
        .DATA_W (W),
        .ROUNDS (R)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .op            (op),
        .data_in       (data_in),
        .key_in        (key_in),
        .busy          (busy),
        .done          (done),
        .result        (result)
`ifdef CRYPTO_EXEC_PARITY_EN
        ,
        .result_parity (result_parity)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int rol(input int v, input int n);
        return ((v << n) | (v >> (W - n))) & MASK;
    endfunction

    // Reference: final result and latency (edges after acceptance until done).
    function automatic void model(input int o, input int d, input int k,
                                  output int res, output int lat);
        int x;
        int kk;
        int t;
        x  = d;
        kk = k;
        case (o)
            0: begin res = (d ^ k) & MASK; lat = 1; end
            1: begin res = (d + k) & MASK; lat = 1; end
            2: begin lat = k % W; res = rol(d, lat); end
            default: begin
                for (int i = 0; i < R; i++) begin
                    t  = x ^ kk;
                    x  = (rol(t, 1) + kk) & MASK;
                    kk = rol(kk, 1);
                end
                res = x;
                lat = R;
            end
        endcase
    endfunction

    // Issue one operation from IDLE (called #1 after an edge) and follow it to IDLE.
    task automatic run_op(input string tag, input int o, input int d, input int k,
                          input bit noise);
        int exp_res;
        int exp_lat;
        int n;
        model(o, d, k, exp_res, exp_lat);
        start   = 1'b1;
        op      = o[1:0];
        data_in = d[W-1:0];
        key_in  = k[W-1:0];
        @(posedge clk); #1;
        start   = 1'b0;
        op      = 2'($urandom);
        data_in = W'($urandom);
        key_in  = W'($urandom);
        check({tag, "_busy_e0"}, 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 64) begin
            if (noise) begin
                start   = 1'($urandom_range(0, 1));
                op      = 2'($urandom);
                data_in = W'($urandom);
                key_in  = W'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_result"}, 32'(result), exp_res);
        check({tag, "_busy_done"}, 32'(busy), 32'd1);
`ifdef CRYPTO_EXEC_PARITY_EN
        check({tag, "_parity"}, 32'(result_parity), 32'(^exp_res[W-1:0]));
`endif
        if (noise) begin
            start   = 1'b1;
            op      = 2'($urandom);
            data_in = W'($urandom);
            key_in  = W'($urandom);
        end
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_done_clr"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_hold"}, 32'(result), exp_res);
    endtask

    initial begin
        bit seen_done;
        reset   = 1'b0;
        start   = 1'b0;
        op      = 2'd0;
        data_in = '0;
        key_in  = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
`ifdef CRYPTO_EXEC_PARITY_EN
        check("rst_parity", 32'(result_parity), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        run_op("xor", 0, 'hA5, 'h0F, 1'b0);
        check("xor_const", 32'(result), 32'hAA);
        run_op("add_wrap", 1, 'hF0, 'h20, 1'b0);
        check("add_const", 32'(result), 32'h10);
        run_op("rol3", 2, 'h81, 'h03, 1'b0);
        check("rol3_const", 32'(result), 32'h0C);
        run_op("rol0", 2, 'h81, 'h08, 1'b0);
        check("rol0_const", 32'(result), 32'h81);
        run_op("mix1", 3, 'h01, 'h00, 1'b0);
        check("mix1_const", 32'(result), 32'h10);
        run_op("mix0", 3, 'h00, 'h00, 1'b0);
        check("mix0_const", 32'(result), 32'h00);
        run_op("add_par", 1, 'h01, 'h00, 1'b0);
        run_op("mix_noise", 3, 'h5A, 'hC3, 1'b1);
        run_op("restart", 0, 'h12, 'h34, 1'b0);

        // Abort a MIX after E2 with reset; result must clear and no done may follow.
        run_op("pre_rst", 0, 'hA5, 'h0F, 1'b0);
        start   = 1'b1;
        op      = 2'd3;
        data_in = 8'h01;
        key_in  = 8'h00;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        check("abort_no_done", 32'(seen_done), 32'd0);
        run_op("post_rst", 0, 'h3C, 'hFF, 1'b0);
        check("post_rst_const", 32'(result), 32'hC3);

        for (int i = 0; i < 40; i++) begin
            run_op($sformatf("rand%0d", i), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)),
                   1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_crypto_exec_unit
